// File: rtl/div.sv
// Sequential 32-bit restoring divider (MIPS DIV/DIVU): quotient to LO, remainder to HI.
// Latency: done 33 clocks after the sampled start (2 clocks for x/0 with DIV_ZERO_FAST_EN).
// Backpressure: div_busy high while iterating; div_start is ignored while busy.
//
// Ports:
//   clk, resetn             clock (rising edge), asynchronous active-low reset
//   div_start, div_signed   request and signedness, sampled when not busy
//   div_src1, div_src2      dividend, divisor, sampled with div_start
//   div_busy, div_done      in-flight flag, one-cycle result-valid pulse
//   div_result_q/_r         quotient (LO) / remainder (HI), held until next result
//
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips the iteration loop.
module div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result_q,
  output logic [WIDTH-1:0] div_result_r
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;     // partial remainder R
  logic [WIDTH-1:0] quo;     // dividend bits shifting out / quotient bits shifting in (Q)
  logic [WIDTH-1:0] dvs;     // |divisor|
  logic             q_neg;
  logic             r_neg;
`ifdef DIV_ZERO_FAST_EN
  logic             zero_fast;
`endif

  // A new request is taken in IDLE and also in FIX, which allows back-to-back issue.
  logic accept;
  assign accept = div_start && (state != S_CALC);

  // Operand magnitudes; negation only applies to signed operands.
  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] src1_abs, src2_abs;
  always_comb begin
    src1_neg = div_signed & div_src1[WIDTH-1];
    src2_neg = div_signed & div_src2[WIDTH-1];
    src1_abs = src1_neg ? -div_src1 : div_src1;
    src2_abs = src2_neg ? -div_src2 : div_src2;
  end

  // One restoring step. The bit shifted out of R is kept (rem_sh is WIDTH+1 bits):
  // with a divisor above 2^31, 2R+1 can exceed 32 bits, and dropping that bit would
  // give a wrong trial result. Compare-then-subtract is the same as testing the sign
  // of the wide difference; the accepted difference always fits in WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             last;
  logic [WIDTH-1:0] fix_q, fix_r;
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
    last    = (cnt == LAST_CNT);
`ifdef DIV_ZERO_FAST_EN
    // Jump straight to what the full loop yields for a zero divisor:
    // every trial succeeds, so Q = all ones and R = |dividend|.
    if (zero_fast) begin
      rem_nxt = quo;
      quo_nxt = '1;
      last    = 1'b1;
    end
`endif
    fix_q = q_neg ? -quo_nxt : quo_nxt;
    fix_r = r_neg ? -rem_nxt : rem_nxt;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (div_start) state_nxt = S_CALC;
      S_CALC:  if (last)      state_nxt = S_FIX;
      S_FIX:   state_nxt = div_start ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only; busy drops in the done cycle.
  always_comb begin
    div_busy = (state == S_CALC);
    div_done = (state == S_FIX);
  end

  // Datapath. Results are written on the last iteration edge so they are
  // visible together with div_done, then held until the next completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_result_q <= '0;
      div_result_r <= '0;
`ifdef DIV_ZERO_FAST_EN
      zero_fast    <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= src1_abs;
      dvs   <= src2_abs;
      q_neg <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
      r_neg <= src1_neg;
`ifdef DIV_ZERO_FAST_EN
      zero_fast <= (div_src2 == '0);
`endif
    end else if (state == S_CALC) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        div_result_q <= fix_q;
        div_result_r <= fix_r;
      end
    end
  end

endmodule
